// File: rtl/ternary_serial_alu_ctrl.sv
// ternary_serial_alu_ctrl: word-level ternary ADD/MIN/MAX sequenced one trit
// per clock, LSB first, behind a start/busy/done handshake.
// Trits use unbalanced 2-bit encoding (00=0, 01=1, 10=2, 11=illegal).
// Optional macro TERNARY_ERR_CHECK_EN: an illegal operand trit aborts the
// operation with err=1. Without it, 11 trits are read as value 2.
module ternary_serial_alu_ctrl #(
    parameter int NUM_TRITS = 4,
    parameter int IDX_W     = $clog2(NUM_TRITS) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [1:0]             op,
    input  logic [2*NUM_TRITS-1:0] operand_a,
    input  logic [2*NUM_TRITS-1:0] operand_b,
    output logic                   busy,
    output logic                   done,
    output logic [2*NUM_TRITS-1:0] result,
    output logic [1:0]             carry_out,
    output logic                   err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [1:0]               r_op;
    logic [2*NUM_TRITS-1:0]   r_a;
    logic [2*NUM_TRITS-1:0]   r_b;
    logic [2*NUM_TRITS-1:0]   r_result;
    logic                     r_carry;
    logic [1:0]               r_carry_out;
    logic                     r_err;
    logic [IDX_W-1:0]         r_idx;

    logic [1:0]               w_ta;
    logic [1:0]               w_tb;
    logic [1:0]               w_va;
    logic [1:0]               w_vb;
    logic [2:0]               w_sum;
    logic [1:0]               w_trit;
    logic                     w_cnext;
    logic                     w_illegal;
    logic                     w_last;

    // Select the latched operand trits addressed by the current index.
    always_comb begin
        w_ta = '0;
        w_tb = '0;
        for (int unsigned i = 0; i < NUM_TRITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_ta = r_a[2*i +: 2];
                w_tb = r_b[2*i +: 2];
            end
        end
    end

    // Trit datapath: add with carry, min, max on the selected trits.
    always_comb begin
        w_va    = (w_ta == 2'b11) ? 2'b10 : w_ta;
        w_vb    = (w_tb == 2'b11) ? 2'b10 : w_tb;
`ifdef TERNARY_ERR_CHECK_EN
        w_illegal = (w_ta == 2'b11) || (w_tb == 2'b11);
`else
        w_illegal = 1'b0;
`endif
        w_sum   = {1'b0, w_va} + {1'b0, w_vb} + {2'b00, r_carry};
        w_trit  = '0;
        w_cnext = 1'b0;
        case (r_op)
            2'b00: begin
                if (w_sum >= 3'd3) begin
                    w_trit  = 2'(w_sum - 3'd3);
                    w_cnext = 1'b1;
                end else begin
                    w_trit  = w_sum[1:0];
                end
            end
            2'b01:   w_trit = (w_va < w_vb) ? w_va : w_vb;
            2'b10:   w_trit = (w_va > w_vb) ? w_va : w_vb;
            default: w_trit = '0;
        endcase
        if (w_illegal) begin
            w_trit  = '0;
            w_cnext = 1'b0;
        end
        w_last = (r_idx == IDX_W'(NUM_TRITS - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (op == 2'b11) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last || w_illegal) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand latch, result accumulation and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_carry_out <= '0;
            r_err       <= 1'b0;
            r_idx       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op        <= op;
                        r_a         <= operand_a;
                        r_b         <= operand_b;
                        r_result    <= '0;
                        r_carry     <= 1'b0;
                        r_carry_out <= '0;
                        r_idx       <= '0;
                        r_err       <= (op == 2'b11);
                    end
                end
                S_RUN: begin
                    for (int unsigned i = 0; i < NUM_TRITS; i++) begin
                        if (r_idx == IDX_W'(i)) begin
                            r_result[2*i +: 2] <= w_trit;
                        end
                    end
                    r_carry <= w_cnext;
                    if (w_illegal) begin
                        r_err <= 1'b1;
                    end else if (w_last) begin
                        r_carry_out <= {1'b0, w_cnext};
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign err       = r_err;

endmodule

// File: tb/tb_ternary_serial_alu_ctrl.sv
// Self-checking bench for ternary_serial_alu_ctrl: directed vectors plus
// randomized operations checked against an integer base-3 reference model.
module tb_ternary_serial_alu_ctrl;

    localparam int N = 4;
    localparam int W = 2 * N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] operand_a = '0;
    logic [W-1:0] operand_b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [1:0]   carry_out;
    logic         err;

    int errors = 0;
    int checks = 0;

    ternary_serial_alu_ctrl #(.NUM_TRITS(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Reference: operands as base-3 integers; lowest illegal trit truncates
    // the operation when error checking is compiled in.
    task automatic model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic [1:0] co, output logic e,
                         output int lat);
        int ta[N];
        int tb[N];
        int k;
        int va;
        int vb;
        int s;
        int p;
        r = '0; co = 2'b00; e = 1'b0; k = N; lat = N + 1;
        for (int i = 0; i < N; i++) begin
            ta[i] = int'(a[2*i +: 2]);
            tb[i] = int'(b[2*i +: 2]);
        end
`ifdef TERNARY_ERR_CHECK_EN
        for (int i = N - 1; i >= 0; i--) if (ta[i] == 3 || tb[i] == 3) k = i;
`else
        for (int i = 0; i < N; i++) begin
            if (ta[i] == 3) ta[i] = 2;
            if (tb[i] == 3) tb[i] = 2;
        end
`endif
        if (o == 2'b11) begin
            e = 1'b1; lat = 1;
            return;
        end
        e   = (k < N);
        lat = (k < N) ? k + 2 : N + 1;
        va = 0; vb = 0; p = 1;
        for (int i = 0; i < k; i++) begin
            va += ta[i] * p; vb += tb[i] * p; p *= 3;
        end
        s = va + vb;
        for (int i = 0; i < k; i++) begin
            if (o == 2'b00) begin
                r[2*i +: 2] = 2'(s % 3);
                s = s / 3;
            end else if (o == 2'b01) begin
                r[2*i +: 2] = 2'((ta[i] < tb[i]) ? ta[i] : tb[i]);
            end else begin
                r[2*i +: 2] = 2'((ta[i] > tb[i]) ? ta[i] : tb[i]);
            end
        end
        if (o == 2'b00 && k == N) co = 2'(s);
    endtask

    // Drive one request, scramble inputs after acceptance, wait for done.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] res, output logic [1:0] co, output logic e,
                          output int lat, output logic busy_ok, output logic done2,
                          output logic [W-1:0] res2);
        @(negedge clk);
        op = o; operand_a = a; operand_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); operand_a = W'($urandom); operand_b = W'($urandom);
        lat = 1; busy_ok = 1'b1;
        while (done !== 1'b1 && lat < 60) begin
            if (busy !== 1'b1 && o != 2'b11) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (busy !== 1'b0) busy_ok = 1'b0;
        res = result; co = carry_out; e = err;
        @(posedge clk); #1;
        done2 = done; res2 = result;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
        checks++; if (carry_out !== 2'b00) begin errors++; $display("FAIL reset_carry got=%b exp=00", carry_out); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_directed(input string name, input logic [1:0] o, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [W-1:0] xr,
                                 input logic [1:0] xc, input logic xe, input int xl);
        logic [W-1:0] res, res2; logic [1:0] co; logic e, bok, d2; int lat;
        run_op(o, a, b, res, co, e, lat, bok, d2, res2);
        checks++; if (res !== xr) begin errors++; $display("FAIL %s_result got=%h exp=%h", name, res, xr); end
        checks++; if (co !== xc) begin errors++; $display("FAIL %s_carry got=%b exp=%b", name, co, xc); end
        checks++; if (e !== xe) begin errors++; $display("FAIL %s_err got=%b exp=%b", name, e, xe); end
        checks++; if (lat != xl) begin errors++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, xl); end
        checks++; if (bok !== 1'b1) begin errors++; $display("FAIL %s_busy got=0 exp=1", name); end
        checks++; if (d2 !== 1'b0) begin errors++; $display("FAIL %s_done_pulse got=%b exp=0", name, d2); end
        checks++; if (res2 !== xr) begin errors++; $display("FAIL %s_hold got=%h exp=%h", name, res2, xr); end
    endtask

    task automatic test_add();
        test_directed("add_ovf", 2'b00, 8'hAA, 8'h01, 8'h00, 2'b01, 1'b0, N + 1);
        test_directed("add_2p2", 2'b00, 8'h02, 8'h02, 8'h05, 2'b00, 1'b0, N + 1);
        test_directed("add_1p1", 2'b00, 8'h01, 8'h01, 8'h02, 2'b00, 1'b0, N + 1);
    endtask

    task automatic test_minmax();
        test_directed("min", 2'b01, 8'h1A, 8'h86, 8'h06, 2'b00, 1'b0, N + 1);
        test_directed("max", 2'b10, 8'h1A, 8'h86, 8'h9A, 2'b00, 1'b0, N + 1);
    endtask

    task automatic test_reserved();
        test_directed("reserved", 2'b11, 8'h55, 8'h22, 8'h00, 2'b00, 1'b1, 1);
    endtask

    task automatic test_illegal();
`ifdef TERNARY_ERR_CHECK_EN
        test_directed("illegal", 2'b00, 8'h0C, 8'h00, 8'h00, 2'b00, 1'b1, 3);
`else
        test_directed("illegal", 2'b00, 8'h0C, 8'h00, 8'h08, 2'b00, 1'b0, N + 1);
`endif
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        op = 2'b00; operand_a = 8'h02; operand_b = 8'h02; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; lat = 1;
        @(negedge clk);
        op = 2'b10; operand_a = 8'hAA; operand_b = 8'hAA; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; lat++;
        while (done !== 1'b1 && lat < 60) begin @(posedge clk); #1; lat++; end
        checks++; if (lat != N + 1) begin errors++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, N + 1); end
        checks++; if (result !== 8'h05) begin errors++; $display("FAIL b2b_result got=%h exp=05", result); end
        @(negedge clk);
        op = 2'b00; operand_a = 8'h01; operand_b = 8'h01; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_done_start_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_start_done got=%b exp=0", done); end
        @(posedge clk); #1;
        checks++; if (result !== 8'h05) begin errors++; $display("FAIL b2b_ignored_result got=%h exp=05", result); end
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        op = 2'b00; operand_a = 8'hAA; operand_b = 8'hAA; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b0; #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_err got=%b exp=0", err); end
        checks++; if (result !== '0) begin errors++; $display("FAIL midrst_result got=%h exp=0", result); end
        checks++; if (carry_out !== 2'b00) begin errors++; $display("FAIL midrst_carry got=%b exp=00", carry_out); end
        @(posedge clk); @(negedge clk); rst_n = 1'b1;
        test_directed("after_rst", 2'b00, 8'hAA, 8'h01, 8'h00, 2'b01, 1'b0, N + 1);
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, res, res2, xr; logic [1:0] o, co, xc; logic e, xe, bok, d2;
        int lat, xl;
        for (int n = 0; n < 60; n++) begin
            o = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a = W'($urandom); b = W'($urandom);
            if (n % 2 == 0) begin
                for (int i = 0; i < N; i++) begin
                    if (a[2*i +: 2] == 2'b11) a[2*i +: 2] = 2'($urandom_range(0, 2));
                    if (b[2*i +: 2] == 2'b11) b[2*i +: 2] = 2'($urandom_range(0, 2));
                end
            end
            model(o, a, b, xr, xc, xe, xl);
            run_op(o, a, b, res, co, e, lat, bok, d2, res2);
            checks++; if (res !== xr) begin errors++; $display("FAIL rnd_result op=%b a=%h b=%h got=%h exp=%h", o, a, b, res, xr); end
            checks++; if (co !== xc) begin errors++; $display("FAIL rnd_carry op=%b a=%h b=%h got=%b exp=%b", o, a, b, co, xc); end
            checks++; if (e !== xe) begin errors++; $display("FAIL rnd_err op=%b a=%h b=%h got=%b exp=%b", o, a, b, e, xe); end
            checks++; if (lat != xl) begin errors++; $display("FAIL rnd_latency op=%b a=%h b=%h got=%0d exp=%0d", o, a, b, lat, xl); end
            checks++; if (bok !== 1'b1) begin errors++; $display("FAIL rnd_busy op=%b got=0 exp=1", o); end
            checks++; if (d2 !== 1'b0 || res2 !== xr) begin errors++; $display("FAIL rnd_hold done=%b res=%h exp done=0 res=%h", d2, res2, xr); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_minmax();
        test_reserved();
        test_illegal();
        test_back_to_back();
        test_reset_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
